param_updown_counter: RTL and testbench
=======================================

Name: param_updown_counter

Overview:
- Parametrised synchronous up/down counter. Successor to the team's fixed 4-bit ripple up counter.
- Adds:
  - configurable width and modulus,
  - direction control,
  - count enable,
  - synchronous parallel load,
  - wrap or saturate mode,
  - terminal-count and overflow indications.
- Used as a general event/decade/timer counter in counter/register designs and their benches.

Parameters:
- WIDTH, 8: counter width in bits; legal range 2..32.
- MAX_VAL, 2**WIDTH-1: highest count value; legal range 1..2**WIDTH-1. MAX_VAL=9 gives a decade counter.
- SATURATE, 0: 0 = wrap at the boundaries; 1 = hold at the boundaries.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset. reset=0 clears all state immediately.
- en, input, 1: count enable.
- up_dn, input, 1: count direction; 1 = up, 0 = down.
- load, input, 1: synchronous parallel load.
- d, input, WIDTH: load value.
- q, output, WIDTH: current count, registered.
- tc, output, 1: terminal count, combinational.
- ovf, output, 1: boundary-crossing pulse, registered.

Behaviour:
- Reset:
  - reset=0 forces q=0 and ovf=0 asynchronously, independent of clk.
  - Takes effect mid-count. Holding reset low through clock edges keeps q=0.
  - On release, the first rising edge with reset=1 evaluates normally.
- Priority at each rising edge: load > en > hold.
- Load:
  - load=1: q <= min(d, MAX_VAL); ovf <= 0.
  - en and up_dn are ignored that cycle.
  - Out-of-range d is clamped to MAX_VAL, never stored.
- Count up (en=1, up_dn=1):
  - q<MAX_VAL: q <= q+1.
  - q==MAX_VAL, SATURATE=0: q <= 0, ovf <= 1.
  - q==MAX_VAL, SATURATE=1: q holds at MAX_VAL, ovf <= 1.
- Count down (en=1, up_dn=0):
  - q>0: q <= q-1.
  - q==0, SATURATE=0: q <= MAX_VAL, ovf <= 1.
  - q==0, SATURATE=1: q holds at 0, ovf <= 1.
- Hold (en=0, load=0): q holds; ovf <= 0.
- ovf:
  - Exactly one cycle high per boundary attempt.
  - Asserted in the cycle after the edge that crossed, or attempted to cross, the boundary.
  - Consecutive attempts in saturate mode keep it high on consecutive cycles.
- tc:
  - tc = en & ~load & ((up_dn & q==MAX_VAL) | (~up_dn & q==0)).
  - High in the cycle before a boundary crossing; usable as a carry-in to cascade a further stage's en.
- Direction change takes effect on the next edge. There is no dead cycle.
- Arithmetic:
  - All compares and increments are WIDTH bits and unsigned.
  - No intermediate value exceeds MAX_VAL or goes below 0.
- Latency: q reflects a load or count one clock after the controlling edge.
- No internal state other than q and ovf.

Test Plan:
- Reset, then en=1, up_dn=1 (WIDTH=4, MAX_VAL=15, SATURATE=0) for 17 clocks:
  - q steps 0..15, then 0, then 1.
  - tc high while q=15.
  - ovf high for exactly one cycle, when q=0.
- Decade wrap (WIDTH=4, MAX_VAL=9):
  - Load d=7, then count up 3 edges: q=8, 9, 0, with one ovf pulse.
  - Load d=12: q=9 (clamped).
- Down count (MAX_VAL=9, SATURATE=0) from q=1:
  - Two down edges give q=0, then 9.
  - tc high when q=0 with up_dn=0.
  - ovf pulses once.
- Saturate mode (SATURATE=1, MAX_VAL=15):
  - From q=14, counting up 4 edges gives q=15, 15, 15, 15.
  - ovf high on 3 consecutive cycles.
  - Down from 0 holds at 0 with ovf high.
- Priority and hold:
  - load=1, en=1, d=5 at q=3: q=5, no ovf.
  - en=0 for 5 clocks: q stays 5, tc=0.
- Async reset mid-count:
  - Drive reset=0 between clock edges while q=6.
  - q=0 and ovf=0 immediately, before the next edge.
  - After release with en=1, the first edge gives q=1.

Source files
------------

// File: rtl/param_updown_counter_if.sv
// Control and status bundle for param_updown_counter.
// The master drives the count controls; the slave (the counter) returns
// the registered count, the terminal-count flag and the overflow pulse.
interface param_updown_counter_if #(
  parameter int WIDTH = 8
) ();

  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             ovf;

  modport master (
    output en, up_dn, load, d,
    input  q, tc, ovf
  );

  modport slave (
    input  en, up_dn, load, d,
    output q, tc, ovf
  );

endinterface

// File: rtl/param_updown_counter.sv
// Parametrised synchronous up/down counter with a configurable modulus,
// wrap or saturate behaviour at the boundaries, clamped parallel load,
// a combinational terminal-count flag for cascading and a registered
// one-cycle overflow pulse.
// The reset input is active-low even though it is named reset.
module param_updown_counter #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL  = '1,
  parameter bit               SATURATE = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  param_updown_counter_if.slave        bus
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             atMax;
  logic             atZero;

  assign atMax  = (count_q == MAX_VAL);
  assign atZero = (count_q == ZERO);

  // Next count and overflow: load wins over counting, counting over hold.
  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    if (bus.load) begin
      count_d = (bus.d > MAX_VAL) ? MAX_VAL : bus.d;
    end else if (bus.en) begin
      if (bus.up_dn) begin
        if (atMax) begin
          ovf_d   = 1'b1;
          count_d = SATURATE ? MAX_VAL : ZERO;
        end else begin
          count_d = count_q + ONE;
        end
      end else begin
        if (atZero) begin
          ovf_d   = 1'b1;
          count_d = SATURATE ? ZERO : MAX_VAL;
        end else begin
          count_d = count_q - ONE;
        end
      end
    end
  end

  // Count and overflow registers, cleared immediately while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= ZERO;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.q   = count_q;
  assign bus.ovf = ovf_q;
  assign bus.tc  = bus.en & ~bus.load &
                   ((bus.up_dn & atMax) | (~bus.up_dn & atZero));

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter. Three instances share clock and
// reset: A is a 4-bit binary wrap counter, B a decade wrap counter and
// C a 4-bit saturating counter. Inputs change 1 time unit after the rising
// edge and outputs are sampled there too, away from the active edge.
module tb_param_updown_counter;

  logic clk;
  logic reset;
  int   checkCount;
  int   passCount;

  param_updown_counter_if #(.WIDTH(4)) busA ();
  param_updown_counter_if #(.WIDTH(4)) busB ();
  param_updown_counter_if #(.WIDTH(4)) busC ();

  param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd15), .SATURATE(1'b0)) dutA (
    .clk(clk), .reset(reset), .bus(busA.slave));
  param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) dutB (
    .clk(clk), .reset(reset), .bus(busB.slave));
  param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd15), .SATURATE(1'b1)) dutC (
    .clk(clk), .reset(reset), .bus(busC.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    busA.en = 0; busA.up_dn = 1; busA.load = 0; busA.d = '0;
    busB.en = 0; busB.up_dn = 1; busB.load = 0; busB.d = '0;
    busC.en = 0; busC.up_dn = 1; busC.load = 0; busC.d = '0;
    repeat (3) step();
    checkCount++;
    if (busA.q !== 4'd0) $display("[TB] FAIL reset_qA: got %0d want 0", busA.q); else passCount++;
    checkCount++;
    if (busB.q !== 4'd0) $display("[TB] FAIL reset_qB: got %0d want 0", busB.q); else passCount++;
    checkCount++;
    if (busC.ovf !== 1'b0) $display("[TB] FAIL reset_ovfC: got %b want 0", busC.ovf); else passCount++;
    reset = 1'b1;
    step();
  endtask

  task automatic test_count_up();
    logic [3:0] expQ;
    busA.en = 1; busA.up_dn = 1;
    #1;
    checkCount++;
    if (busA.tc !== 1'b0) $display("[TB] FAIL up_tc_start: got %b want 0", busA.tc); else passCount++;
    for (int i = 1; i <= 17; i++) begin
      step();
      expQ = 4'(i % 16);
      checkCount++;
      if (busA.q !== expQ) $display("[TB] FAIL up_q[%0d]: got %0d want %0d", i, busA.q, expQ); else passCount++;
      checkCount++;
      if (busA.ovf !== (i == 16)) $display("[TB] FAIL up_ovf[%0d]: got %b want %b", i, busA.ovf, (i == 16)); else passCount++;
      checkCount++;
      if (busA.tc !== (expQ == 4'd15)) $display("[TB] FAIL up_tc[%0d]: got %b want %b", i, busA.tc, (expQ == 4'd15)); else passCount++;
    end
    busA.en = 0;
    step();
  endtask

  task automatic test_decade();
    logic [3:0] expSeq [3];
    logic       expOvf [3];
    expSeq = '{4'd8, 4'd9, 4'd0};
    expOvf = '{1'b0, 1'b0, 1'b1};
    busB.load = 1; busB.d = 4'd7;
    step();
    checkCount++;
    if (busB.q !== 4'd7) $display("[TB] FAIL dec_load7: got %0d want 7", busB.q); else passCount++;
    busB.load = 0; busB.en = 1; busB.up_dn = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checkCount++;
      if (busB.q !== expSeq[i]) $display("[TB] FAIL dec_q[%0d]: got %0d want %0d", i, busB.q, expSeq[i]); else passCount++;
      checkCount++;
      if (busB.ovf !== expOvf[i]) $display("[TB] FAIL dec_ovf[%0d]: got %b want %b", i, busB.ovf, expOvf[i]); else passCount++;
      if (i == 1) begin
        checkCount++;
        if (busB.tc !== 1'b1) $display("[TB] FAIL dec_tc_at9: got %b want 1", busB.tc); else passCount++;
      end
    end
    busB.en = 0; busB.load = 1; busB.d = 4'd12;
    step();
    checkCount++;
    if (busB.q !== 4'd9) $display("[TB] FAIL dec_clamp: got %0d want 9", busB.q); else passCount++;
    checkCount++;
    if (busB.ovf !== 1'b0) $display("[TB] FAIL dec_clamp_ovf: got %b want 0", busB.ovf); else passCount++;
    busB.load = 0;
  endtask

  task automatic test_down();
    busB.load = 1; busB.d = 4'd1;
    step();
    busB.load = 0; busB.en = 1; busB.up_dn = 0;
    #1;
    checkCount++;
    if (busB.tc !== 1'b0) $display("[TB] FAIL down_tc_at1: got %b want 0", busB.tc); else passCount++;
    step();
    checkCount++;
    if (busB.q !== 4'd0) $display("[TB] FAIL down_q0: got %0d want 0", busB.q); else passCount++;
    checkCount++;
    if (busB.tc !== 1'b1) $display("[TB] FAIL down_tc_at0: got %b want 1", busB.tc); else passCount++;
    checkCount++;
    if (busB.ovf !== 1'b0) $display("[TB] FAIL down_ovf_early: got %b want 0", busB.ovf); else passCount++;
    step();
    checkCount++;
    if (busB.q !== 4'd9) $display("[TB] FAIL down_wrap: got %0d want 9", busB.q); else passCount++;
    checkCount++;
    if (busB.ovf !== 1'b1) $display("[TB] FAIL down_ovf: got %b want 1", busB.ovf); else passCount++;
    busB.en = 0;
    step();
    checkCount++;
    if (busB.ovf !== 1'b0) $display("[TB] FAIL down_ovf_end: got %b want 0", busB.ovf); else passCount++;
    checkCount++;
    if (busB.q !== 4'd9) $display("[TB] FAIL down_hold: got %0d want 9", busB.q); else passCount++;
  endtask

  task automatic test_saturate();
    busC.load = 1; busC.d = 4'd14;
    step();
    busC.load = 0; busC.en = 1; busC.up_dn = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      checkCount++;
      if (busC.q !== 4'd15) $display("[TB] FAIL sat_q[%0d]: got %0d want 15", i, busC.q); else passCount++;
      checkCount++;
      if (busC.ovf !== (i > 0)) $display("[TB] FAIL sat_ovf[%0d]: got %b want %b", i, busC.ovf, (i > 0)); else passCount++;
    end
    busC.en = 0; busC.load = 1; busC.d = 4'd0;
    step();
    checkCount++;
    if (busC.ovf !== 1'b0) $display("[TB] FAIL sat_load_ovf: got %b want 0", busC.ovf); else passCount++;
    busC.load = 0; busC.en = 1; busC.up_dn = 0;
    step();
    checkCount++;
    if (busC.q !== 4'd0) $display("[TB] FAIL sat_down_q: got %0d want 0", busC.q); else passCount++;
    checkCount++;
    if (busC.ovf !== 1'b1) $display("[TB] FAIL sat_down_ovf: got %b want 1", busC.ovf); else passCount++;
    busC.en = 0;
    step();
  endtask

  task automatic test_priority();
    busA.load = 1; busA.d = 4'd3; busA.en = 0;
    step();
    busA.load = 1; busA.en = 1; busA.up_dn = 1; busA.d = 4'd5;
    #1;
    checkCount++;
    if (busA.tc !== 1'b0) $display("[TB] FAIL prio_tc_load: got %b want 0", busA.tc); else passCount++;
    step();
    checkCount++;
    if (busA.q !== 4'd5) $display("[TB] FAIL prio_q: got %0d want 5", busA.q); else passCount++;
    checkCount++;
    if (busA.ovf !== 1'b0) $display("[TB] FAIL prio_ovf: got %b want 0", busA.ovf); else passCount++;
    busA.load = 1; busA.d = 4'd15;
    step();
    step();
    checkCount++;
    if (busA.q !== 4'd15) $display("[TB] FAIL prio_load_at_max: got %0d want 15", busA.q); else passCount++;
    checkCount++;
    if (busA.ovf !== 1'b0) $display("[TB] FAIL prio_load_at_max_ovf: got %b want 0", busA.ovf); else passCount++;
    busA.d = 4'd5;
    step();
    busA.load = 0; busA.en = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      checkCount++;
      if (busA.q !== 4'd5) $display("[TB] FAIL hold_q[%0d]: got %0d want 5", i, busA.q); else passCount++;
      checkCount++;
      if (busA.tc !== 1'b0) $display("[TB] FAIL hold_tc[%0d]: got %b want 0", i, busA.tc); else passCount++;
    end
  endtask

  task automatic test_async_reset();
    busA.en = 1; busA.up_dn = 1;
    busC.load = 1; busC.d = 4'd15;
    step();
    busC.load = 0; busC.en = 1; busC.up_dn = 1;
    step();
    busA.en = 0;
    checkCount++;
    if (busA.q !== 4'd7) $display("[TB] FAIL ar_pre_qA: got %0d want 7", busA.q); else passCount++;
    busA.load = 1; busA.d = 4'd6;
    step();
    busA.load = 0;
    checkCount++;
    if (busC.ovf !== 1'b1) $display("[TB] FAIL ar_pre_ovfC: got %b want 1", busC.ovf); else passCount++;
    #2;
    reset = 1'b0;
    #1;
    checkCount++;
    if (busA.q !== 4'd0) $display("[TB] FAIL ar_qA: got %0d want 0", busA.q); else passCount++;
    checkCount++;
    if (busC.ovf !== 1'b0) $display("[TB] FAIL ar_ovfC: got %b want 0", busC.ovf); else passCount++;
    checkCount++;
    if (busC.q !== 4'd0) $display("[TB] FAIL ar_qC: got %0d want 0", busC.q); else passCount++;
    busA.en = 1; busA.up_dn = 1;
    step();
    checkCount++;
    if (busA.q !== 4'd0) $display("[TB] FAIL ar_held_qA: got %0d want 0", busA.q); else passCount++;
    reset = 1'b1;
    step();
    checkCount++;
    if (busA.q !== 4'd1) $display("[TB] FAIL ar_release_qA: got %0d want 1", busA.q); else passCount++;
    busA.en = 0; busC.en = 0;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    test_reset();
    test_count_up();
    test_decade();
    test_down();
    test_saturate();
    test_priority();
    test_async_reset();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
